// File: rtl/serdes_8b10b_pkg.sv
// Shared types and constants for the 8b10b rx byte-order alignment controller.
package serdes_8b10b_pkg;

   // Byte lanes in the 64-bit rx word and the width of a lane index.
   localparam int NUM_BYTES = 8;
   localparam int LANE_W    = 3;

   // K28.5 comma character.
   localparam logic [7:0] K28_5 = 8'hBC;

   typedef enum logic [1:0] {
      ST_LOS   = 2'd0,
      ST_ACQ   = 2'd1,
      ST_SYNC  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

endpackage

// File: rtl/serdes_8b10b_comma_detect.sv
// Stage 1: registers a per-word comma qualification (single K byte equal to
// the comma character), the lane it sits in, and a word-level code error.
module serdes_8b10b_comma_detect
   import serdes_8b10b_pkg::*;
#(
   parameter logic [7:0] COMMA_BYTE = K28_5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [63:0]          rx_data,
   input  logic [7:0]           rx_k_ctrl,
   input  logic [7:0]           rx_code_err,
   output logic                 comma_hit,
   output logic [LANE_W-1:0]    pos,
   output logic                 word_err
);

   logic                onehot;
   logic [LANE_W-1:0]   pos_c;
   logic                hit_c;

   // A word with several K bytes is not a comma, so only a one-hot K mask qualifies.
   always_comb begin
      onehot = (rx_k_ctrl != 8'd0) && ((rx_k_ctrl & (rx_k_ctrl - 8'd1)) == 8'd0);
      pos_c  = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (rx_k_ctrl[i]) pos_c = LANE_W'(i);
      end
      hit_c = onehot && (rx_data[8*pos_c +: 8] == COMMA_BYTE);
   end

   // Register the qualified result; this is the single stage-1 pipeline step.
   always_ff @(posedge clk) begin
      if (rst) begin
         comma_hit <= 1'b0;
         pos       <= '0;
         word_err  <= 1'b0;
      end else begin
         comma_hit <= hit_c;
         pos       <= pos_c;
         word_err  <= |rx_code_err;
      end
   end

endmodule

// File: rtl/serdes_8b10b_rx_align_ctrl.sv
// Link-sync controller: qualifies K28.5 commas for a consistent lane, locks
// the byte-order select once sync is declared, and tracks loss of sync.
module serdes_8b10b_rx_align_ctrl
   import serdes_8b10b_pkg::*;
#(
   parameter logic [7:0] COMMA_BYTE    = K28_5,
   parameter int         ACQ_CNT       = 4,     // must be >= 2
   parameter int         LOSS_ERR      = 4,
   parameter int         GOOD_RUN      = 16,
   parameter int         COMMA_TIMEOUT = 4096
) (
   input  logic        I_rx_clk,
   input  logic        I_rst,
   input  logic [63:0] I_rx_data,
   input  logic [7:0]  I_rx_k_ctrl,
   input  logic [7:0]  I_rx_code_err,
   input  logic        I_cnt_clr,
   output logic [3:0]  O_adjust_sel,
   output logic        O_adjust_sel_vld,
   output logic        O_sync_ok,
   output logic        O_realign_pulse,
   output logic [15:0] O_loss_cnt
);

   localparam int          MW       = $clog2(ACQ_CNT + 1);
   localparam int          EW       = $clog2(LOSS_ERR + 1);
   localparam int          GW       = $clog2(GOOD_RUN + 1);
   localparam logic [15:0] TMO_LAST = 16'(COMMA_TIMEOUT - 1);

   logic                comma_hit;
   logic                word_err;
   logic [LANE_W-1:0]   pos;

   state_t              state;
   logic [LANE_W-1:0]   cand_pos;
   logic [LANE_W-1:0]   sel;
   logic [MW-1:0]       match_cnt;
   logic [EW-1:0]       err_cnt;
   logic [GW-1:0]       good_cnt;
   logic [15:0]         tmo_cnt;
   logic                sync_ok;
   logic                sel_vld;
   logic                realign_pulse;
   logic [15:0]         loss_cnt;

   logic                good_comma;
   logic                bad_word;
   logic                tmo_hit;
   logic                lose_sync;

   serdes_8b10b_comma_detect #(
      .COMMA_BYTE (COMMA_BYTE)
   ) u_comma_detect (
      .clk         (I_rx_clk),
      .rst         (I_rst),
      .rx_data     (I_rx_data),
      .rx_k_ctrl   (I_rx_k_ctrl),
      .rx_code_err (I_rx_code_err),
      .comma_hit   (comma_hit),
      .pos         (pos),
      .word_err    (word_err)
   );

   // Word classification against the locked lane, and the single loss-of-sync
   // decision shared by the FSM and the loss counter. A timeout fires on a
   // missing good comma while the counter already sits at its last value, so
   // a comma arriving on that word still rescues the link.
   always_comb begin
      good_comma = comma_hit && !word_err && (pos == sel);
      bad_word   = word_err || (comma_hit && (pos != sel));
      tmo_hit    = !good_comma && (tmo_cnt == TMO_LAST);
      lose_sync  = 1'b0;
      if (state == ST_SYNC)
         lose_sync = tmo_hit;
      else if (state == ST_CHECK)
         lose_sync = tmo_hit || (bad_word && (err_cnt == EW'(LOSS_ERR - 1)));
   end

   // Sync FSM with registered outputs; the select holds its value across loss.
   always_ff @(posedge I_rx_clk) begin
      if (I_rst) begin
         state         <= ST_LOS;
         cand_pos      <= '0;
         sel           <= '0;
         match_cnt     <= '0;
         err_cnt       <= '0;
         good_cnt      <= '0;
         tmo_cnt       <= '0;
         sync_ok       <= 1'b0;
         sel_vld       <= 1'b0;
         realign_pulse <= 1'b0;
      end else begin
         realign_pulse <= 1'b0;
         if (lose_sync) begin
            state         <= ST_LOS;
            sync_ok       <= 1'b0;
            sel_vld       <= 1'b0;
            realign_pulse <= 1'b1;
            err_cnt       <= '0;
            good_cnt      <= '0;
            tmo_cnt       <= '0;
         end else begin
            case (state)
               ST_LOS: begin
                  if (comma_hit && !word_err) begin
                     state     <= ST_ACQ;
                     cand_pos  <= pos;
                     match_cnt <= MW'(1);
                  end
               end
               ST_ACQ: begin
                  if (word_err) begin
                     state <= ST_LOS;
                  end else if (comma_hit) begin
                     if (pos != cand_pos) begin
                        cand_pos  <= pos;
                        match_cnt <= MW'(1);
                     end else if (match_cnt == MW'(ACQ_CNT - 1)) begin
                        state    <= ST_SYNC;
                        sel      <= cand_pos;
                        sel_vld  <= 1'b1;
                        sync_ok  <= 1'b1;
                        tmo_cnt  <= '0;
                        err_cnt  <= '0;
                        good_cnt <= '0;
                     end else begin
                        match_cnt <= match_cnt + MW'(1);
                     end
                  end
               end
               ST_SYNC: begin
                  tmo_cnt <= good_comma ? 16'd0 : tmo_cnt + 16'd1;
                  if (bad_word) begin
                     state    <= ST_CHECK;
                     err_cnt  <= EW'(1);
                     good_cnt <= '0;
                  end
               end
               ST_CHECK: begin
                  tmo_cnt <= good_comma ? 16'd0 : tmo_cnt + 16'd1;
                  if (bad_word) begin
                     err_cnt  <= err_cnt + EW'(1);
                     good_cnt <= '0;
                  end else if (good_cnt == GW'(GOOD_RUN - 1)) begin
                     good_cnt <= '0;
                     err_cnt  <= err_cnt - EW'(1);
                     if (err_cnt == EW'(1)) state <= ST_SYNC;
                  end else begin
                     good_cnt <= good_cnt + GW'(1);
                  end
               end
               default: state <= ST_LOS;
            endcase
         end
      end
   end

   // Saturating loss counter; a clear wins over a same-cycle loss.
   always_ff @(posedge I_rx_clk) begin
      if (I_rst || I_cnt_clr)
         loss_cnt <= '0;
      else if (lose_sync && (loss_cnt != 16'hFFFF))
         loss_cnt <= loss_cnt + 16'd1;
   end

   assign O_adjust_sel     = {{(4-LANE_W){1'b0}}, sel};
   assign O_adjust_sel_vld = sel_vld;
   assign O_sync_ok        = sync_ok;
   assign O_realign_pulse  = realign_pulse;
   assign O_loss_cnt       = loss_cnt;

endmodule

// File: tb/tb_serdes_8b10b_rx_align_ctrl.sv
// Bench for the rx align controller: each driven word may push its expected
// outputs into a scoreboard, which are compared two clocks later.
module tb_serdes_8b10b_rx_align_ctrl;

   localparam logic [63:0] IDLE = 64'h0706050403020100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] data = IDLE;
   logic [7:0]  k = 8'h00;
   logic [7:0]  cerr = 8'h00;
   logic        clr = 1'b0;
   logic [3:0]  sel;
   logic        sel_vld;
   logic        sync_ok;
   logic        pulse;
   logic [15:0] loss;

   always #5 clk = ~clk;

   serdes_8b10b_rx_align_ctrl dut (
      .I_rx_clk         (clk),
      .I_rst            (rst),
      .I_rx_data        (data),
      .I_rx_k_ctrl      (k),
      .I_rx_code_err    (cerr),
      .I_cnt_clr        (clr),
      .O_adjust_sel     (sel),
      .O_adjust_sel_vld (sel_vld),
      .O_sync_ok        (sync_ok),
      .O_realign_pulse  (pulse),
      .O_loss_cnt       (loss)
   );

   typedef struct {
      int          due;
      string       tag;
      logic        sync;
      logic        pulse;
      logic [3:0]  sel;
      logic [15:0] loss;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [3:0]  cur_sel = 4'd0;
   logic [15:0] cur_loss = 16'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample #1 later, and retire any due expectations.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk({e.tag, " sync"},  32'(sync_ok), 32'(e.sync));
         chk({e.tag, " vld"},   32'(sel_vld), 32'(e.sync));
         chk({e.tag, " pulse"}, 32'(pulse),   32'(e.pulse));
         chk({e.tag, " sel"},   32'(sel),     32'(e.sel));
         chk({e.tag, " loss"},  32'(loss),    32'(e.loss));
      end
   endtask

   task automatic word(input logic [63:0] d, input logic [7:0] kk, input logic [7:0] ee,
                       input logic cl, input bit en, input logic xs, input logic xp,
                       input string tag);
      data = d;
      k    = kk;
      cerr = ee;
      clr  = cl;
      if (en) sb.push_back(exp_t'{cyc + 2, tag, xs, xp, cur_sel, cur_loss});
      tick();
   endtask

   function automatic logic [63:0] cdata(input int p);
      logic [63:0] d;
      d = IDLE;
      d[8*p +: 8] = 8'hBC;
      return d;
   endfunction

   task automatic comma(input int p, input bit en, input logic xs, input string tag);
      word(cdata(p), 8'(1 << p), 8'h00, 1'b0, en, xs, 1'b0, tag);
   endtask

   task automatic idle(input bit en, input logic xs, input string tag);
      word(IDLE, 8'h00, 8'h00, 1'b0, en, xs, 1'b0, tag);
   endtask

   task automatic errw(input bit en, input logic xs, input logic xp, input string tag);
      word(IDLE, 8'h00, 8'h01, 1'b0, en, xs, xp, tag);
   endtask

   // Four commas at lane p from LOS; lock is expected on the fourth.
   task automatic lock(input int p, input string tag);
      for (int i = 0; i < 3; i++) comma(p, 1'b1, 1'b0, {tag, " acq"});
      cur_sel = 4'(p);
      comma(p, 1'b1, 1'b1, {tag, " lock"});
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst sel",   32'(sel),     32'h0);
      chk("rst vld",   32'(sel_vld), 32'h0);
      chk("rst sync",  32'(sync_ok), 32'h0);
      chk("rst pulse", 32'(pulse),   32'h0);
      chk("rst loss",  32'(loss),    32'h0);
      rst = 1'b0;

      // Lock at lane 3: sync exactly two clocks after the fourth comma
      idle(1'b1, 1'b0, "t1 idle");
      lock(3, "t1");
      idle(1'b1, 1'b1, "t1 hold");

      // Stray comma at lane 6, recovery, then three errors and long clean run
      comma(6, 1'b1, 1'b1, "t3 stray");
      for (int i = 0; i < 16; i++) idle(1'b1, 1'b1, "t3 repay");
      for (int i = 0; i < 3; i++) errw(1'b1, 1'b1, 1'b0, "t3 err");
      for (int i = 0; i < 256; i++) begin
         if (i % 8 == 0) comma(3, 1'b1, 1'b1, "t3 clean");
         else            idle(1'b1, 1'b1, "t3 clean");
      end

      // Four consecutive code errors from SYNC: loss
      for (int i = 0; i < 3; i++) errw(1'b1, 1'b1, 1'b0, "t4 err");
      cur_loss = 16'd1;
      errw(1'b1, 1'b0, 1'b1, "t4 loss");
      idle(1'b1, 1'b0, "t4 pulse end");

      // ACQ: error restarts acquisition, multi-K word ignored, lane change
      comma(3, 1'b1, 1'b0, "t2 c3");
      comma(3, 1'b1, 1'b0, "t2 c3");
      errw(1'b1, 1'b0, 1'b0, "t2 acq err");
      comma(3, 1'b1, 1'b0, "t2 c3");
      comma(3, 1'b1, 1'b0, "t2 c3");
      word(64'h07060504BC0201BC, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "t2 multi k");
      comma(3, 1'b1, 1'b0, "t2 c3");
      for (int i = 0; i < 3; i++) comma(5, 1'b1, 1'b0, "t2 c5");
      cur_sel = 4'd5;
      comma(5, 1'b1, 1'b1, "t2 lock5");

      // GOOD_RUN-1 clean words do not repay a credit
      errw(1'b1, 1'b1, 1'b0, "t5 err1");
      for (int i = 0; i < 15; i++) idle(1'b1, 1'b1, "t5 short run");
      errw(1'b1, 1'b1, 1'b0, "t5 err2");
      errw(1'b1, 1'b1, 1'b0, "t5 err3");
      cur_loss = 16'd2;
      errw(1'b1, 1'b0, 1'b1, "t5 loss");
      idle(1'b1, 1'b0, "t5 after");

      // Comma timeout: 4095 idle words then a comma survives, 4096 does not
      lock(5, "t6");
      for (int i = 1; i <= 4095; i++) idle(i == 4095, 1'b1, "t6 idle 4095");
      comma(5, 1'b1, 1'b1, "t6 rescue");
      for (int i = 1; i <= 4096; i++) begin
         if (i == 4096) begin
            cur_loss = 16'd3;
            word(IDLE, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "t6 timeout");
         end else begin
            idle(i == 4095, 1'b1, "t6 pre timeout");
         end
      end
      idle(1'b1, 1'b0, "t6 after");

      // Saturation with a preset counter, then clear against a same-cycle loss
      lock(3, "t7");
      idle(1'b0, 1'b0, "");
      idle(1'b0, 1'b0, "");
      force dut.loss_cnt = 16'hFFFE;
      #1;
      release dut.loss_cnt;
      cur_loss = 16'hFFFE;
      idle(1'b1, 1'b1, "t7 preset");
      for (int i = 0; i < 3; i++) errw(1'b1, 1'b1, 1'b0, "t7 err");
      cur_loss = 16'hFFFF;
      errw(1'b1, 1'b0, 1'b1, "t7 to max");
      lock(3, "t7b");
      for (int i = 0; i < 3; i++) errw(1'b1, 1'b1, 1'b0, "t7b err");
      errw(1'b1, 1'b0, 1'b1, "t7 sat");
      lock(3, "t7c");
      for (int i = 0; i < 3; i++) errw(1'b1, 1'b1, 1'b0, "t7c err");
      cur_loss = 16'd0;
      errw(1'b1, 1'b0, 1'b1, "t7 clr loss");
      word(IDLE, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "t7 clr hold");

      // Reset in the middle of CHECK
      lock(3, "t8");
      for (int i = 0; i < 3; i++) errw(1'b1, 1'b1, 1'b0, "t8 err");
      cur_loss = 16'd1;
      errw(1'b1, 1'b0, 1'b1, "t8 loss");
      lock(3, "t8b");
      errw(1'b1, 1'b1, 1'b0, "t8 check");
      idle(1'b0, 1'b0, "");
      idle(1'b0, 1'b0, "");
      rst = 1'b1;
      tick();
      chk("t8 rst sel",   32'(sel),     32'h0);
      chk("t8 rst vld",   32'(sel_vld), 32'h0);
      chk("t8 rst sync",  32'(sync_ok), 32'h0);
      chk("t8 rst pulse", 32'(pulse),   32'h0);
      chk("t8 rst loss",  32'(loss),    32'h0);
      rst = 1'b0;
      cur_sel  = 4'd0;
      cur_loss = 16'd0;
      lock(3, "t8 relock");
      idle(1'b1, 1'b1, "t8 end");

      tick();
      tick();
      chk("sb drain", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
